// File: rtl/fp_add_iter.sv
// Iterative IEEE-754 single-precision adder: one alignment shift or normalisation
// step per cycle, truncating rounding, denormals flushed to zero, Inf/NaN reported as Inf.
module fp_add_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        inf
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t      state, state_d;
  logic        live;
  logic        sign_q, sign_d;
  logic        sub_q, sub_d;
  logic [7:0]  exp_q, exp_d;
  logic [23:0] m_l_q, m_l_d;
  logic [23:0] m_s_q, m_s_d;
  logic [4:0]  diff_q, diff_d;
  logic [24:0] sum_q, sum_d;
  logic [31:0] result_d;
  logic        inf_d;

  // Operand ordering and unpacking at the accept edge.
  logic        x_ge_y;
  logic [31:0] op_l, op_s;
  logic [7:0]  exp_l, exp_s, exp_gap;
  logic [23:0] man_l, man_s;
  logic        accept;

  assign x_ge_y  = (x[30:0] >= y[30:0]);
  assign op_l    = x_ge_y ? x : y;
  assign op_s    = x_ge_y ? y : x;
  assign exp_l   = op_l[30:23];
  assign exp_s   = op_s[30:23];
  assign exp_gap = exp_l - exp_s;
  assign man_l   = (exp_l == 8'd0) ? 24'd0 : {1'b1, op_l[22:0]};
  assign man_s   = (exp_s == 8'd0) ? 24'd0 : {1'b1, op_s[22:0]};

  // in_ready stays low through reset and the first edge after release.
  assign in_ready  = live && (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state;
    sign_d   = sign_q;
    sub_d    = sub_q;
    exp_d    = exp_q;
    m_l_d    = m_l_q;
    m_s_d    = m_s_q;
    diff_d   = diff_q;
    sum_d    = sum_q;
    result_d = result;
    inf_d    = inf;

    unique case (state)
      IDLE: begin
        if (accept) begin
          sign_d = op_l[31];
          sub_d  = op_l[31] ^ op_s[31];
          exp_d  = exp_l;
          m_l_d  = man_l;
          if (exp_l == 8'hFF || exp_s == 8'hFF) begin
            result_d = {op_l[31], 31'h7F80_0000};
            inf_d    = 1'b1;
            state_d  = DONE;
          end else begin
            if (exp_gap > 8'd24) begin
              m_s_d  = 24'd0;
              diff_d = 5'd0;
            end else begin
              m_s_d  = man_s;
              diff_d = exp_gap[4:0];
            end
            state_d = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (diff_q != 5'd0) begin
          m_s_d  = m_s_q >> 1;
          diff_d = diff_q - 5'd1;
        end else begin
          state_d = ADD;
        end
      end

      ADD: begin
        // L has the larger magnitude, so the difference never goes negative.
        sum_d   = sub_q ? ({1'b0, m_l_q} - {1'b0, m_s_q})
                        : ({1'b0, m_l_q} + {1'b0, m_s_q});
        state_d = NORM;
      end

      NORM: begin
        if (sum_q == 25'd0) begin
          result_d = 32'h0000_0000;
          inf_d    = 1'b0;
          state_d  = DONE;
        end else if (sum_q[24]) begin
          sum_d = sum_q >> 1;
          exp_d = exp_q + 8'd1;
          if (exp_q == 8'hFE) begin
            result_d = {sign_q, 31'h7F80_0000};
            inf_d    = 1'b1;
            state_d  = DONE;
          end
        end else if (!sum_q[23] && exp_q > 8'd1) begin
          sum_d = sum_q << 1;
          exp_d = exp_q - 8'd1;
        end else if (!sum_q[23]) begin
          result_d = 32'h0000_0000;
          inf_d    = 1'b0;
          state_d  = DONE;
        end else begin
          result_d = {sign_q, exp_q, sum_q[22:0]};
          inf_d    = 1'b0;
          state_d  = DONE;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: all datapath registers are reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state  <= IDLE;
      live   <= 1'b0;
      sign_q <= 1'b0;
      sub_q  <= 1'b0;
      exp_q  <= 8'd0;
      m_l_q  <= 24'd0;
      m_s_q  <= 24'd0;
      diff_q <= 5'd0;
      sum_q  <= 25'd0;
      result <= 32'd0;
      inf    <= 1'b0;
    end else begin
      state  <= state_d;
      live   <= 1'b1;
      sign_q <= sign_d;
      sub_q  <= sub_d;
      exp_q  <= exp_d;
      m_l_q  <= m_l_d;
      m_s_q  <= m_s_d;
      diff_q <= diff_d;
      sum_q  <= sum_d;
      result <= result_d;
      inf    <= inf_d;
    end
  end

endmodule

// File: tb/tb_fp_add_iter.sv
// Directed-vector bench for fp_add_iter: hand-computed sums, latencies,
// backpressure and mid-operation reset.
module tb_fp_add_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] x = 32'd0;
  logic [31:0] y = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
  logic        inf;

  int total = 0;
  int passed = 0;
  int failed = 0;

  fp_add_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .inf       (inf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with the block idle; returns in DONE
  // (and, when out_ready is high, after the return to IDLE).
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_inf, input int exp_lat);
    int lat;
    lat = 0;
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    x = a;
    y = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 32'hDEAD_BEEF;
    y = 32'h1234_5678;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result, exp_res);
    check({tag, " inf"}, {31'd0, inf}, {31'd0, exp_inf});
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, " back to idle"}, {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] held;
    int seen;

    #12;
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset inf", {31'd0, inf}, 32'd0);
    #10 rst_n = 1'b1;
    #1 check("ready low before first edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("ready after release", {31'd0, in_ready}, 32'd1);

    // Latency counts edges after the accept edge until out_valid is seen.
    run_op("1+1",        32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 4);
    run_op("1-1",        32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0, 3);
    run_op("align",      32'h3E80_0000, 32'h3FC0_0000, 32'h3FE0_0000, 1'b0, 5);
    run_op("1.5-1",      32'h3FC0_0000, 32'hBF80_0000, 32'h3F00_0000, 1'b0, 4);
    run_op("-1.5+1",     32'hBFC0_0000, 32'h3F80_0000, 32'hBF00_0000, 1'b0, 4);
    run_op("inf+1",      32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b1, 0);
    run_op("1+-inf",     32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000, 1'b1, 0);
    run_op("nan+0",      32'h7FC0_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 0);
    run_op("overflow",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1, 3);
    run_op("denorm+1",   32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 3);
    run_op("gap25",      32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000, 1'b0, 3);
    run_op("gap24",      32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1'b0, 27);
    run_op("flush exp1", 32'h0080_0000, 32'h8080_0001, 32'h0000_0000, 1'b0, 3);

    // Backpressure: result must stay put and new operands must be ignored.
    out_ready = 1'b0;
    run_op("bp", 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 4);
    held = result;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      x = 32'h4040_0000;
      y = 32'h4040_0000;
      @(posedge clk); #1;
      check("bp result held", result, held);
      check("bp out_valid", {31'd0, out_valid}, 32'd1);
      check("bp in_ready low", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp released out_valid", {31'd0, out_valid}, 32'd0);
    check("bp released in_ready", {31'd0, in_ready}, 32'd1);

    // Reset during ALIGN of a two-shift alignment.
    x = 32'h3E80_0000;
    y = 32'h3FC0_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst inf", {31'd0, inf}, 32'd0);
    check("midrst in_ready", {31'd0, in_ready}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst ready after release", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("midrst no stale result", seen, 0);
    check("midrst result stays 0", result, 32'd0);

    run_op("post reset", 32'h3E80_0000, 32'h3FC0_0000, 32'h3FE0_0000, 1'b0, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
